// File: rtl/pulse_sync_detect.sv
// Destination-side receiver for a stretched event level: synchronises it, turns each
// rising edge into a one-cycle pulse, and tracks pending/ack, event count and overrun.
module pulse_sync_detect #(
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inp,
    input  logic               ack,
    input  logic               clr,
    output logic               q,
    output logic               pending,
    output logic               overrun,
    output logic [COUNT_W-1:0] count
);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
            $error("pulse_sync_detect: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    // sync_pipe[0] is the only flop that may go metastable; later stages resolve it
    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   sync_out;
    logic                   sync_d;
    logic                   evt;

    state_t                 state;
    state_t                 state_nxt;
    logic                   overrun_nxt;
    logic [COUNT_W-1:0]     count_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_pipe <= '0;
            sync_d    <= 1'b0;
            q         <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], inp};
            sync_d    <= sync_out;
            q         <= evt;
        end
    end

    assign sync_out = sync_pipe[SYNC_STAGES-1];
    assign evt      = sync_out & ~sync_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            overrun <= 1'b0;
            count   <= '0;
        end else begin
            state   <= state_nxt;
            overrun <= overrun_nxt;
            count   <= count_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        overrun_nxt = overrun;
        count_nxt   = count;

        case (state)
            IDLE: begin
                if (evt)
                    state_nxt = PEND;
            end
            PEND: begin
                // a fresh event that lands together with ack simply replaces the old one
                if (evt && !ack)
                    overrun_nxt = 1'b1;
                else if (ack && !evt)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (evt && (count != {COUNT_W{1'b1}}))
            count_nxt = count + COUNT_W'(1);

        // clear wins over ack but still records an event arriving on the same edge
        if (clr) begin
            overrun_nxt = 1'b0;
            count_nxt   = evt ? COUNT_W'(1) : '0;
            state_nxt   = evt ? PEND : IDLE;
        end
    end

    assign pending = (state == PEND);

endmodule

// File: doc/pulse_sync_detect.md
Name: pulse_sync_detect

Overview:
- Destination-domain consumer of the pulse stretcher output.
- Synchronises the stretched level `inp`, which is asynchronous to `clk`, through an N-flop chain, then detects rising edges and emits one-cycle event pulses on `q`.
- Holds a pending/ack handshake toward the local consumer, a saturating event counter and a sticky overrun flag.
- Sits between the stretcher and domain-local control logic.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal range 2..4, values outside the range are a synthesis-time error.
- COUNT_W, 8, width of the event counter.

Ports:
- clk  input  1  destination-domain clock.
- rst  input  1  reset; asynchronous, active-high, clears every flop.
- inp  input  1  stretched event level from the stretcher; asynchronous to clk.
- ack  input  1  consumer acknowledge; clears pending.
- clr  input  1  synchronous clear of count, overrun and pending.
- q  output  1  one-cycle event pulse, registered.
- pending  output  1  an event has occurred and is not yet acknowledged.
- overrun  output  1  sticky: an event arrived while pending was still set.
- count  output  COUNT_W  number of events since reset/clr, saturating.

Behaviour:
- Reset: the sync chain, edge register, q, pending, overrun and count are all 0, asynchronously; no event pulse is generated during rst.
- Synchroniser: s[0] samples inp; s[i] samples s[i-1]; sync_out = s[SYNC_STAGES-1]; sync_d = sync_out delayed one cycle.
- Event: evt = sync_out & ~sync_d; q is registered evt.
- Latency: the first rising edge that samples inp=1 is edge 1; q is high during the cycle after edge SYNC_STAGES+1 (edge 3 for the default); q is high for exactly 1 cycle per event.
- Detection rules:
  - A high phase of inp sampled high by at least 1 clk edge yields exactly 1 event.
  - Two events need at least one edge sampling inp=0 between them.
  - A high level lasting many cycles yields 1 event only; a falling edge yields none.
- Metastability: the first stage may resolve either way. A pulse straddling an edge is detected at most one cycle late and is never doubled.
- Reset release with inp already high: the chain fills and one event is reported at edge SYNC_STAGES+1 after release.
- Handshake FSM, 2 states:
  - IDLE (pending=0) --evt--> PEND.
  - PEND --ack & ~evt--> IDLE.
  - PEND --ack & evt--> PEND: the new event replaces the old one; overrun is not set.
  - PEND --evt & ~ack--> PEND, and overrun is set to 1.
  - ack in IDLE is ignored.
  - pending rises on the same edge that q rises.
- Counter: +1 on every evt; holds at 2^COUNT_W-1 and never wraps; saturation does not set overrun.
- clr, synchronous, has priority over ack. It sets count=0, overrun=0 and pending=0.
- clr on the same edge as evt: count=1, pending=1, overrun=0.
- clr does not touch the sync chain, sync_d or q.
- rst mid-event: all state is lost. If inp is still high after release, the reset-release rule applies.

Test Plan:
- clk period 100 ns, inp 1 -> 0 after 1 stretched pulse of 150 ns -> q is high for exactly 1 cycle, 3 edges after the first sampling edge; pending=1, count=1, overrun=0.
- 3 isolated pulses each 250 ns wide, gaps of 300 ns, ack pulsed 1 cycle after each q -> 3 q pulses, count=3, pending ends 0, overrun=0.
- 2 pulses with no ack -> overrun=1 after the second q, pending=1, count=2; then clr -> count=0, overrun=0, pending=0.
- ack asserted on the same edge as the second evt -> pending stays 1, overrun stays 0.
- COUNT_W=2, 5 pulses -> count reads 1,2,3,3,3; 5 q pulses total.
- inp held high 1 µs -> a single q pulse. Separately: inp high while rst deasserts -> one q at edge 3 after release. Separately: rst asserted mid-chain fill -> all outputs 0 immediately.
